// File: rtl/pe_fifo_pkg.sv
// pe_fifo_pkg: shared FIFO/unpacker defaults, read-side state encoding and sizing helper
package pe_fifo_pkg;
  localparam int WIDTH_DATA_DEF = 8;
  localparam int R_PARAM_DEF = 4;
  localparam int CNT_WIDTH_DEF = 8;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    CAPT  = 3'd2,
    DRAIN = 3'd3,
    FIN   = 3'd4
  } state_e;
  function automatic int idx_width(input int r);
    return r > 1 ? $clog2(r) : 1;
  endfunction
endpackage

// File: rtl/fifo_chunk_unpacker.sv
// fifo_chunk_unpacker: holds one popped chunk and walks it oldest word (MSB slice) first
module fifo_chunk_unpacker import pe_fifo_pkg::*; #(
  parameter int WIDTH_DATA = WIDTH_DATA_DEF,
  parameter int R_PARAM = R_PARAM_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr,
  input  logic                            capture,
  input  logic                            advance,
  input  logic [WIDTH_DATA*R_PARAM-1:0]   fifo_data,
  output logic [WIDTH_DATA-1:0]           word,
  output logic                            word_last
);
  localparam int IW = idx_width(R_PARAM);
  logic [WIDTH_DATA*R_PARAM-1:0] hold_q, hold_d;
  logic [IW-1:0] idx_q, idx_d;
  assign word_last = idx_q == IW'(R_PARAM - 1);
  // load a fresh chunk on capture, step the word index on each accepted beat
  always_comb begin
    hold_d = capture ? fifo_data : hold_q;
    idx_d = (capture || (advance && word_last)) ? '0 : advance ? idx_q + IW'(1) : idx_q;
  end
  // word select; index 0 is the oldest word in the top slice
  always_comb begin
    word = '0;
    for (int i = 0; i < R_PARAM; i++)
      if (idx_q == IW'(i)) word = hold_q[(R_PARAM-i)*WIDTH_DATA-1 -: WIDTH_DATA];
  end
  // abort discards whatever chunk was held
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hold_q <= '0;
      idx_q <= '0;
    end else begin
      hold_q <= hold_d;
      idx_q <= idx_d;
    end
  end
endmodule

// File: rtl/fifo_read_unpacker.sv
// fifo_read_unpacker: pops R_PARAM-word FIFO chunks and streams them one word per beat
module fifo_read_unpacker import pe_fifo_pkg::*; #(
  parameter int WIDTH_DATA = WIDTH_DATA_DEF,
  parameter int R_PARAM = R_PARAM_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [CNT_WIDTH-1:0]          num_chunks,
  input  logic                          abort,
  input  logic                          fifo_able_read,
  input  logic [WIDTH_DATA*R_PARAM-1:0] fifo_data,
  output logic                          fifo_read_en,
  output logic [WIDTH_DATA-1:0]         out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done,
  output logic [CNT_WIDTH-1:0]          chunks_left
);
  state_e state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic word_last;
  assign fifo_read_en = state_q == FETCH && fifo_able_read;
  assign out_valid = state_q == DRAIN;
  assign out_last = out_valid && word_last && cnt_q == '0;
  assign busy = state_q != IDLE;
  assign done = state_q == FIN;
  assign chunks_left = cnt_q;
  fifo_chunk_unpacker #(.WIDTH_DATA(WIDTH_DATA), .R_PARAM(R_PARAM)) u_unpack (
    .clk(clk),
    .rst(rst),
    .clr(abort),
    .capture(state_q == CAPT),
    .advance(out_valid && out_ready),
    .fifo_data(fifo_data),
    .word(out_data),
    .word_last(word_last)
  );
  // job sequencing; abort overrides every transition including a same-cycle start
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = num_chunks != '0 ? FETCH : FIN;
        cnt_d = num_chunks;
      end
      FETCH: if (fifo_able_read) begin
        state_d = CAPT;
        cnt_d = cnt_q - CNT_WIDTH'(1);
      end
      CAPT: state_d = DRAIN;
      DRAIN: if (out_ready && word_last) state_d = cnt_q != '0 ? FETCH : FIN;
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end
  // state and chunk counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
endmodule
